// File: rtl/i2c_slave_reg16.sv
// i2c_slave_reg16: I2C responder, 8-bit register pointer, 16-bit data MSB first.
// Define I2C_SLAVE_AUTOINC_EN to auto-increment the pointer across words.
module i2c_slave_reg16 #(
  parameter logic [7:0]  SLAVE_ID = 8'h78,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i2c_sclk,
  inout  wire         i2c_sdat,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [15:0] reg_rdata,
  output logic        i2c_busy
);

`ifdef I2C_SLAVE_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  localparam int unsigned CW =
    (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_LEN - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_DEV_ACK,
    S_REG,
    S_REG_ACK,
    S_WH,
    S_WH_ACK,
    S_WL,
    S_WL_ACK,
    S_RD,
    S_RD_ACK,
    S_IGNORE
  } state_e;

  // synchronizer and glitch filter state
  logic          scl_s1_q, scl_s2_q, scl_f_q, scl_f_d, scl_p_q;
  logic          sda_s1_q, sda_s2_q, sda_f_q, sda_f_d, sda_p_q;
  logic [CW-1:0] scl_cnt_q, scl_cnt_d;
  logic [CW-1:0] sda_cnt_q, sda_cnt_d;

  // protocol state
  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  wh_q, wh_d;
  logic        rw_q, rw_d;
  logic        rd_lo_q, rd_lo_d;
  logic        mack_q, mack_d;
  logic        wr_block_q, wr_block_d;
  logic        rd_pend_q, rd_pend_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic        reg_wr_en_q, reg_wr_en_d;
  logic        reg_rd_en_q, reg_rd_en_d;
  logic        i2c_busy_q, i2c_busy_d;

  logic       scl_rise, scl_fall;
  logic       start_ev, stop_ev;
  logic [7:0] rx_byte;

  assign i2c_sdat  = sda_oe_q ? 1'b0 : 1'bz;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_wr_en = reg_wr_en_q;
  assign reg_rd_en = reg_rd_en_q;
  assign i2c_busy  = i2c_busy_q;

  assign scl_rise = scl_f_q & ~scl_p_q;
  assign scl_fall = ~scl_f_q & scl_p_q;
  assign start_ev = scl_f_q & scl_p_q
                  & sda_p_q & ~sda_f_q;
  assign stop_ev  = scl_f_q & scl_p_q
                  & ~sda_p_q & sda_f_q;
  assign rx_byte  = {shift_q[6:0], sda_f_q};

  // SCL filter: accept a new level only after FILT_LEN stable cycles
  always_comb begin
    scl_cnt_d = '0;
    scl_f_d   = scl_f_q;
    if (scl_s2_q != scl_f_q) begin
      if (scl_cnt_q == CNT_MAX) scl_f_d = scl_s2_q;
      else scl_cnt_d = scl_cnt_q + CW'(1);
    end
  end

  // SDA filter: same rule as SCL so both paths share latency
  always_comb begin
    sda_cnt_d = '0;
    sda_f_d   = sda_f_q;
    if (sda_s2_q != sda_f_q) begin
      if (sda_cnt_q == CNT_MAX) sda_f_d = sda_s2_q;
      else sda_cnt_d = sda_cnt_q + CW'(1);
    end
  end

  // protocol next-state: START/STOP override, then SCL edges
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    wh_d        = wh_q;
    rw_d        = rw_q;
    rd_lo_d     = rd_lo_q;
    mack_d      = mack_q;
    wr_block_d  = wr_block_q;
    rd_pend_d   = reg_rd_en_q;
    sda_oe_d    = sda_oe_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_wr_en_d = 1'b0;
    reg_rd_en_d = 1'b0;
    i2c_busy_d  = i2c_busy_q;

    // read data is valid the cycle after the request
    if (rd_pend_q) tx_d = reg_rdata;

    unique case (1'b1)
      stop_ev: begin
        state_d    = S_IDLE;
        sda_oe_d   = 1'b0;
        i2c_busy_d = 1'b0;
      end
      start_ev: begin
        state_d    = S_DEV;
        bit_cnt_d  = '0;
        sda_oe_d   = 1'b0;
        i2c_busy_d = 1'b1;
        rd_lo_d    = 1'b0;
        wr_block_d = 1'b0;
      end
      scl_rise: begin
        case (state_q)
          S_DEV, S_REG, S_WH, S_WL: begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = rx_byte;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (state_q == S_REG)
                  reg_addr_d = rx_byte;
                if (state_q == S_WL && !wr_block_q) begin
                  reg_wr_en_d = 1'b1;
                  reg_wdata_d = {wh_q, rx_byte};
                  wr_block_d  = ~AUTOINC;
                end
              end
            end
          end
          S_RD: begin
            if (bit_cnt_q < 4'd8)
              bit_cnt_d = bit_cnt_q + 4'd1;
          end
          S_RD_ACK: begin
            mack_d = ~sda_f_q;
            if (rd_lo_q && !sda_f_q) begin
              reg_rd_en_d = 1'b1;
              if (AUTOINC)
                reg_addr_d = reg_addr_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
      scl_fall: begin
        case (state_q)
          S_DEV: begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              if (shift_q[7:1] == SLAVE_ID[7:1]) begin
                state_d     = S_DEV_ACK;
                sda_oe_d    = 1'b1;
                rw_d        = shift_q[0];
                reg_rd_en_d = shift_q[0];
              end else begin
                state_d = S_IGNORE;
              end
            end
          end
          S_DEV_ACK: begin
            bit_cnt_d = '0;
            if (rw_q) begin
              state_d  = S_RD;
              rd_lo_d  = 1'b0;
              sda_oe_d = ~tx_q[15];
            end else begin
              state_d  = S_REG;
              sda_oe_d = 1'b0;
            end
          end
          S_REG, S_WH, S_WL: begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b1;
              bit_cnt_d = '0;
              if (state_q == S_REG)
                state_d = S_REG_ACK;
              else if (state_q == S_WH) begin
                state_d = S_WH_ACK;
                wh_d    = shift_q;
              end else begin
                state_d = S_WL_ACK;
                if (AUTOINC)
                  reg_addr_d = reg_addr_q + 8'd1;
              end
            end
          end
          S_REG_ACK, S_WL_ACK: begin
            state_d   = S_WH;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
          S_WH_ACK: begin
            state_d   = S_WL;
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
          S_RD: begin
            if (bit_cnt_q == 4'd8) begin
              tx_d      = {tx_q[14:0], 1'b0};
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              state_d   = S_RD_ACK;
            end else if (bit_cnt_q != 4'd0) begin
              tx_d     = {tx_q[14:0], 1'b0};
              sda_oe_d = ~tx_q[14];
            end
          end
          S_RD_ACK: begin
            bit_cnt_d = '0;
            if (!rd_lo_q || mack_q) begin
              state_d  = S_RD;
              rd_lo_d  = ~rd_lo_q;
              sda_oe_d = ~tx_q[15];
            end else begin
              state_d  = S_IGNORE;
              sda_oe_d = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // all state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      scl_f_q     <= 1'b1;
      scl_p_q     <= 1'b1;
      scl_cnt_q   <= '0;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      sda_f_q     <= 1'b1;
      sda_p_q     <= 1'b1;
      sda_cnt_q   <= '0;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      wh_q        <= '0;
      rw_q        <= 1'b0;
      rd_lo_q     <= 1'b0;
      mack_q      <= 1'b0;
      wr_block_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      sda_oe_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      i2c_busy_q  <= 1'b0;
    end else begin
      scl_s1_q    <= i2c_sclk;
      scl_s2_q    <= scl_s1_q;
      scl_f_q     <= scl_f_d;
      scl_p_q     <= scl_f_q;
      scl_cnt_q   <= scl_cnt_d;
      sda_s1_q    <= i2c_sdat;
      sda_s2_q    <= sda_s1_q;
      sda_f_q     <= sda_f_d;
      sda_p_q     <= sda_f_q;
      sda_cnt_q   <= sda_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      wh_q        <= wh_d;
      rw_q        <= rw_d;
      rd_lo_q     <= rd_lo_d;
      mack_q      <= mack_d;
      wr_block_q  <= wr_block_d;
      rd_pend_q   <= rd_pend_d;
      sda_oe_q    <= sda_oe_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_wr_en_q <= reg_wr_en_d;
      reg_rd_en_q <= reg_rd_en_d;
      i2c_busy_q  <= i2c_busy_d;
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg16.sv
// tb_i2c_slave_reg16: directed bus-level bench for i2c_slave_reg16.
// Define I2C_SLAVE_AUTOINC_EN to check the auto-increment build.
module tb_i2c_slave_reg16;
  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scl = 1'b1;
  logic        m_oe = 1'b0;
  logic [15:0] rdata = 16'h5640;
  wire         sda;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic        busy;

  int checks = 0;
  int passes = 0;
  int wr_n = 0;
  int rd_n = 0;
  int drv_n = 0;
  logic [7:0]  wa_q[$];
  logic [15:0] wd_q[$];

  assign sda = m_oe ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_slave_reg16 dut (
    .clk(clk),
    .rst_n(rst_n),
    .i2c_sclk(scl),
    .i2c_sdat(sda),
    .reg_addr(reg_addr),
    .reg_wdata(reg_wdata),
    .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en),
    .reg_rdata(rdata),
    .i2c_busy(busy)
  );

  // log register-port pulses and slave bus drive
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_n++;
      wa_q.push_back(reg_addr);
      wd_q.push_back(reg_wdata);
    end
    if (reg_rd_en) rd_n++;
    if (!m_oe && sda === 1'b0) drv_n++;
  end

  task automatic bit_xfer(input logic b, output logic r);
    m_oe = ~b;
    #T;
    scl = 1'b1;
    #T;
    r = sda;
    scl = 1'b0;
    #T;
  endtask

  task automatic i2c_start();
    m_oe = 1'b0;
    #T;
    scl = 1'b1;
    #T;
    m_oe = 1'b1;
    #T;
    scl = 1'b0;
    #T;
  endtask

  task automatic i2c_stop();
    m_oe = 1'b1;
    #T;
    scl = 1'b1;
    #T;
    m_oe = 1'b0;
    #T;
    #T;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(~mack, r);
  endtask

  task automatic test_reset();
    checks++; if (reg_addr !== 8'h00) $display("FAIL rst_addr got %h exp 00", reg_addr); else passes++;
    checks++; if (reg_wdata !== 16'h0) $display("FAIL rst_wdata got %h exp 0000", reg_wdata); else passes++;
    checks++; if (reg_wr_en !== 1'b0) $display("FAIL rst_wr_en got %b exp 0", reg_wr_en); else passes++;
    checks++; if (reg_rd_en !== 1'b0) $display("FAIL rst_rd_en got %b exp 0", reg_rd_en); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else passes++;
    checks++; if (sda !== 1'b1) $display("FAIL rst_sda got %b exp 1", sda); else passes++;
  endtask

  task automatic test_write();
    logic a;
    int acks = 0;
    int w0 = wr_n;
    i2c_start();
    checks++; if (busy !== 1'b1) $display("FAIL wr_busy_mid got %b exp 1", busy); else passes++;
    write_byte(8'h78, a); acks += int'(a);
    write_byte(8'h3A, a); acks += int'(a);
    write_byte(8'h12, a); acks += int'(a);
    write_byte(8'h34, a); acks += int'(a);
    i2c_stop();
    checks++; if (acks != 4) $display("FAIL wr_acks got %0d exp 4", acks); else passes++;
    checks++; if (wr_n - w0 != 1) $display("FAIL wr_count got %0d exp 1", wr_n - w0); else passes++;
    checks++; if (wa_q[$] !== 8'h3A) $display("FAIL wr_addr got %h exp 3a", wa_q[$]); else passes++;
    checks++; if (wd_q[$] !== 16'h1234) $display("FAIL wr_data got %h exp 1234", wd_q[$]); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL wr_busy_end got %b exp 0", busy); else passes++;
  endtask

  task automatic test_read();
    logic a;
    logic [7:0] d0, d1;
    int acks = 0;
    int r0 = rd_n;
    int w0 = wr_n;
    i2c_start();
    write_byte(8'h78, a); acks += int'(a);
    write_byte(8'h0A, a); acks += int'(a);
    i2c_start();
    write_byte(8'h79, a); acks += int'(a);
    read_byte(1'b1, d0);
    read_byte(1'b0, d1);
    i2c_stop();
    checks++; if (acks != 3) $display("FAIL rd_acks got %0d exp 3", acks); else passes++;
    checks++; if (d0 !== 8'h56) $display("FAIL rd_byte_h got %h exp 56", d0); else passes++;
    checks++; if (d1 !== 8'h40) $display("FAIL rd_byte_l got %h exp 40", d1); else passes++;
    checks++; if (rd_n - r0 != 1) $display("FAIL rd_en_count got %0d exp 1", rd_n - r0); else passes++;
    checks++; if (reg_addr !== 8'h0A) $display("FAIL rd_addr got %h exp 0a", reg_addr); else passes++;
    checks++; if (wr_n - w0 != 0) $display("FAIL rd_no_write got %0d exp 0", wr_n - w0); else passes++;
  endtask

  task automatic test_wrong_id();
    logic a;
    int acks = 0;
    int w0 = wr_n;
    int v0 = drv_n;
    i2c_start();
    write_byte(8'h7A, a); acks += int'(a);
    checks++; if (a !== 1'b0) $display("FAIL id_nack got ack=%b exp 0", a); else passes++;
    write_byte(8'h3A, a); acks += int'(a);
    write_byte(8'h12, a); acks += int'(a);
    write_byte(8'h34, a); acks += int'(a);
    i2c_stop();
    checks++; if (acks != 0) $display("FAIL id_acks got %0d exp 0", acks); else passes++;
    checks++; if (wr_n - w0 != 0) $display("FAIL id_no_write got %0d exp 0", wr_n - w0); else passes++;
    checks++; if (drv_n - v0 != 0) $display("FAIL id_sda_driven got %0d exp 0", drv_n - v0); else passes++;
  endtask

  task automatic test_partial();
    logic a;
    int w0 = wr_n;
    i2c_start();
    write_byte(8'h78, a);
    write_byte(8'h3A, a);
    write_byte(8'h12, a);
    i2c_stop();
    checks++; if (wr_n - w0 != 0) $display("FAIL part_no_write got %0d exp 0", wr_n - w0); else passes++;
    checks++; if (sda !== 1'b1) $display("FAIL part_sda got %b exp 1", sda); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL part_busy got %b exp 0", busy); else passes++;
  endtask

  task automatic test_back_to_back();
    logic a;
    int acks = 0;
    int w0 = wr_n;
    i2c_start();
    write_byte(8'h78, a); acks += int'(a);
    write_byte(8'h3A, a); acks += int'(a);
    write_byte(8'h12, a); acks += int'(a);
    write_byte(8'h34, a); acks += int'(a);
    write_byte(8'h56, a); acks += int'(a);
    write_byte(8'h78, a); acks += int'(a);
    i2c_stop();
    checks++; if (acks != 6) $display("FAIL b2b_acks got %0d exp 6", acks); else passes++;
`ifdef I2C_SLAVE_AUTOINC_EN
    checks++; if (wr_n - w0 != 2) $display("FAIL b2b_count got %0d exp 2", wr_n - w0); else passes++;
    checks++; if (wa_q[$] !== 8'h3B) $display("FAIL b2b_addr2 got %h exp 3b", wa_q[$]); else passes++;
    checks++; if (wd_q[$] !== 16'h5678) $display("FAIL b2b_data2 got %h exp 5678", wd_q[$]); else passes++;
    checks++; if (reg_addr !== 8'h3C) $display("FAIL b2b_ptr got %h exp 3c", reg_addr); else passes++;
`else
    checks++; if (wr_n - w0 != 1) $display("FAIL b2b_count got %0d exp 1", wr_n - w0); else passes++;
    checks++; if (wa_q[$] !== 8'h3A) $display("FAIL b2b_addr got %h exp 3a", wa_q[$]); else passes++;
    checks++; if (wd_q[$] !== 16'h1234) $display("FAIL b2b_data got %h exp 1234", wd_q[$]); else passes++;
    checks++; if (reg_addr !== 8'h3A) $display("FAIL b2b_ptr got %h exp 3a", reg_addr); else passes++;
`endif
  endtask

  task automatic test_reset_ack();
    logic a, r;
    logic [7:0] id = 8'h78;
    int acks = 0;
    int w0;
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(id[i], r);
    m_oe = 1'b0;
    #T;
    checks++; if (sda !== 1'b0) $display("FAIL rack_driven got %b exp 0", sda); else passes++;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (sda !== 1'b1) $display("FAIL rack_release got %b exp 1", sda); else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (reg_addr !== 8'h00) $display("FAIL rack_addr got %h exp 00", reg_addr); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL rack_busy got %b exp 0", busy); else passes++;
    #T;
    w0 = wr_n;
    i2c_start();
    write_byte(8'h78, a); acks += int'(a);
    write_byte(8'h44, a); acks += int'(a);
    write_byte(8'hAB, a); acks += int'(a);
    write_byte(8'hCD, a); acks += int'(a);
    i2c_stop();
    checks++; if (acks != 4) $display("FAIL rack_acks got %0d exp 4", acks); else passes++;
    checks++; if (wr_n - w0 != 1) $display("FAIL rack_count got %0d exp 1", wr_n - w0); else passes++;
    checks++; if (wa_q[$] !== 8'h44) $display("FAIL rack_waddr got %h exp 44", wa_q[$]); else passes++;
    checks++; if (wd_q[$] !== 16'hABCD) $display("FAIL rack_wdata got %h exp abcd", wd_q[$]); else passes++;
  endtask

  task automatic test_glitch();
    @(negedge clk);
    m_oe = 1'b1;
    @(negedge clk);
    m_oe = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL glitch_start got busy=%b exp 0", busy); else passes++;
    i2c_start();
    scl = 1'b1;
    #T;
    @(negedge clk);
    m_oe = 1'b0;
    @(negedge clk);
    m_oe = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (busy !== 1'b1) $display("FAIL glitch_stop got busy=%b exp 1", busy); else passes++;
    m_oe = 1'b0;
    #T;
    checks++; if (busy !== 1'b0) $display("FAIL glitch_real_stop got busy=%b exp 0", busy); else passes++;
  endtask

  initial begin
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_wrong_id();
    test_partial();
    test_back_to_back();
    test_reset_ack();
    test_glitch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
